// File: rtl/reg_incr_pipe_pkg.sv
// Shared constants and per-stage flag record for the elastic incrementer pipe.
package reg_incr_pkg;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Width-independent part of a stage; stages extend it with a W-bit msg.
  typedef struct packed {
    logic val;
    logic sat;
    logic ovf;
  } stage_flags_t;
endpackage

// File: rtl/reg_incr_pipe_if.sv
// Val/rdy producer and consumer bundle of the incrementer pipe.
interface reg_incr_pipe_if #(
  parameter int W       = 8,
  parameter int NSTAGES = 2
);
  localparam int OCC_W = $clog2(NSTAGES + 1);

  logic             in_val;
  logic             in_rdy;
  logic [W-1:0]     in_msg;
  logic             in_sat;
  logic             out_val;
  logic             out_rdy;
  logic [W-1:0]     out_msg;
  logic             out_ovf;
  logic [OCC_W-1:0] occupancy;

  modport master (
    output in_val, in_msg, in_sat, out_rdy,
    input  in_rdy, out_val, out_msg, out_ovf, occupancy
  );

  modport slave (
    input  in_val, in_msg, in_sat, out_rdy,
    output in_rdy, out_val, out_msg, out_ovf, occupancy
  );
endinterface

// File: rtl/reg_incr_pipe_stage.sv
// One elastic stage: registers the upstream word plus STEP (wrap or saturate),
// holding its contents while the downstream side stalls.
module reg_incr_stage
  import reg_incr_pkg::*;
#(
  parameter int W    = 8,
  parameter int STEP = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_val_i,
  output logic         up_rdy_o,
  input  logic [W-1:0] up_msg_i,
  input  logic         up_sat_i,
  input  logic         up_ovf_i,
  output logic         dn_val_o,
  input  logic         dn_rdy_i,
  output logic [W-1:0] dn_msg_o,
  output logic         dn_sat_o,
  output logic         dn_ovf_o
);
  typedef struct packed {
    stage_flags_t f;
    logic [W-1:0] msg;
  } stage_t;

  localparam logic [W:0] STEP_X = (W+1)'(STEP);

  stage_t st_q, st_d;

  function automatic stage_t incr(input logic [W-1:0] msg, input logic sat, input logic ovf);
    logic [W:0] s;
    stage_t     r;
    s       = {1'b0, msg} + STEP_X;
    r.f.val = 1'b1;
    r.f.sat = sat;
    r.f.ovf = ovf | s[W];
    if (sat == MODE_WRAP || !s[W]) r.msg = s[W-1:0];
    else                           r.msg = {W{1'b1}};
    return r;
  endfunction

  assign up_rdy_o = !st_q.f.val || dn_rdy_i;

  // Load on handshake; an empty handoff only drops val, data is don't-care.
  always_comb begin
    st_d = st_q;
    if (up_rdy_o) begin
      st_d.f.val = up_val_i;
      if (up_val_i) st_d = incr(up_msg_i, up_sat_i, up_ovf_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= '0;
    else        st_q <= st_d;
  end

  assign dn_val_o = st_q.f.val;
  assign dn_msg_o = st_q.msg;
  assign dn_sat_o = st_q.f.sat;
  assign dn_ovf_o = st_q.f.ovf;
endmodule

// File: rtl/reg_incr_pipe.sv
// NSTAGES-deep elastic register+increment pipeline with per-word wrap/saturate
// mode, sticky overflow and a live occupancy count.
module reg_incr_pipe
  import reg_incr_pkg::*;
#(
  parameter int W       = 8,
  parameter int NSTAGES = 2,
  parameter int STEP    = 1
) (
  input  logic            clk,
  input  logic            reset,
  reg_incr_pipe_if.slave  bus
);
  localparam int OCC_W = $clog2(NSTAGES + 1);

  // Index 0 is the producer side, index NSTAGES the consumer side.
  logic         val [NSTAGES+1];
  logic         rdy [NSTAGES+1];
  logic [W-1:0] msg [NSTAGES+1];
  logic         sat [NSTAGES+1];
  logic         ovf [NSTAGES+1];
  logic [OCC_W-1:0] occ;
  logic         unused_sat;

  assign val[0]       = bus.in_val;
  assign msg[0]       = bus.in_msg;
  assign sat[0]       = bus.in_sat;
  assign ovf[0]       = 1'b0;
  assign rdy[NSTAGES] = bus.out_rdy;

  for (genvar g = 0; g < NSTAGES; g++) begin : g_stage
    reg_incr_stage #(.W(W), .STEP(STEP)) u_stage (
      .clk      (clk),
      .rst_n    (reset),
      .up_val_i (val[g]),
      .up_rdy_o (rdy[g]),
      .up_msg_i (msg[g]),
      .up_sat_i (sat[g]),
      .up_ovf_i (ovf[g]),
      .dn_val_o (val[g+1]),
      .dn_rdy_i (rdy[g+1]),
      .dn_msg_o (msg[g+1]),
      .dn_sat_o (sat[g+1]),
      .dn_ovf_o (ovf[g+1])
    );
  end

  always_comb begin
    occ = '0;
    for (int i = 1; i <= NSTAGES; i++) occ = occ + OCC_W'(val[i]);
  end

  assign unused_sat    = sat[NSTAGES];
  assign bus.in_rdy    = rdy[0];
  assign bus.out_val   = val[NSTAGES];
  assign bus.out_msg   = msg[NSTAGES];
  assign bus.out_ovf   = ovf[NSTAGES];
  assign bus.occupancy = occ;
endmodule

// File: tb/tb_reg_incr_pipe.sv
// Directed bench for reg_incr_pipe: a W=8/N=2/STEP=1 instance plus a
// W=8/N=4/STEP=0x40 instance driven against a reference queue.
module tb_reg_incr_pipe;
  import reg_incr_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  reg_incr_pipe_if #(.W(8), .NSTAGES(2)) a ();
  reg_incr_pipe_if #(.W(8), .NSTAGES(4)) b ();

  reg_incr_pipe #(.W(8), .NSTAGES(2), .STEP(1))  dut_a (.clk(clk), .reset(reset), .bus(a.slave));
  reg_incr_pipe #(.W(8), .NSTAGES(4), .STEP(64)) dut_b (.clk(clk), .reset(reset), .bus(b.slave));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [7:0] outq_a [$];
  int         outcyc_a [$];
  logic [8:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: NSTAGES=4, STEP=0x40 applied stage by stage, returns {ovf,msg}.
  function automatic logic [8:0] model_b(input logic [7:0] m, input logic s);
    logic [8:0] sum;
    logic       o;
    o = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sum = {1'b0, m} + 9'h040;
      o   = o | sum[8];
      m   = (s && sum[8]) ? 8'hFF : sum[7:0];
    end
    return {o, m};
  endfunction

  task automatic step_a(input logic v, input logic [7:0] m, input logic s, input logic r,
                        output logic acc);
    @(negedge clk);
    a.in_val = v; a.in_msg = m; a.in_sat = s; a.out_rdy = r;
    #1;
    acc = v && a.in_rdy;
    if (a.out_val && r) begin
      outq_a.push_back(a.out_msg);
      outcyc_a.push_back(cyc);
    end
    cyc++;
  endtask

  task automatic single_a(input string tag, input logic [7:0] m, input logic s,
                          input logic [7:0] em, input logic eo);
    @(negedge clk);
    a.in_val = 1'b1; a.in_msg = m; a.in_sat = s; a.out_rdy = 1'b1;
    #1 chk({tag, "_in_rdy"}, 32'(a.in_rdy), 32'd1);
    @(negedge clk);
    a.in_val = 1'b0;
    chk({tag, "_occ1"}, 32'(a.occupancy), 32'd1);
    chk({tag, "_early_val"}, 32'(a.out_val), 32'd0);
    @(negedge clk);
    chk({tag, "_val"}, 32'(a.out_val), 32'd1);
    chk({tag, "_msg"}, 32'(a.out_msg), 32'(em));
    chk({tag, "_ovf"}, 32'(a.out_ovf), 32'(eo));
    @(negedge clk);
    chk({tag, "_drain_val"}, 32'(a.out_val), 32'd0);
    chk({tag, "_drain_occ"}, 32'(a.occupancy), 32'd0);
  endtask

  task automatic single_b(input string tag, input logic [7:0] m, input logic s,
                          input logic [7:0] em, input logic eo);
    int k;
    @(negedge clk);
    b.in_val = 1'b1; b.in_msg = m; b.in_sat = s; b.out_rdy = 1'b1;
    #1 chk({tag, "_in_rdy"}, 32'(b.in_rdy), 32'd1);
    @(negedge clk);
    b.in_val = 1'b0;
    k = 1;
    while (!b.out_val && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_latency"}, 32'(k), 32'd4);
    chk({tag, "_msg"}, 32'(b.out_msg), 32'(em));
    chk({tag, "_ovf"}, 32'(b.out_ovf), 32'(eo));
    @(negedge clk);
    chk({tag, "_drain_val"}, 32'(b.out_val), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic       acc;
    logic [7:0] nxt;
    int         n;
    int         got;
    int         sent;
    logic       prev_stall;
    logic [8:0] prev_out;
    logic [8:0] e;

    a.in_val = 1'b0; a.in_msg = '0; a.in_sat = 1'b0; a.out_rdy = 1'b0;
    b.in_val = 1'b0; b.in_msg = '0; b.in_sat = 1'b0; b.out_rdy = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_val", 32'(a.out_val), 32'd0);
    chk("rst_out_msg", 32'(a.out_msg), 32'd0);
    chk("rst_out_ovf", 32'(a.out_ovf), 32'd0);
    chk("rst_occ", 32'(a.occupancy), 32'd0);
    chk("rst_b_occ", 32'(b.occupancy), 32'd0);
    reset = 1'b1;
    #1 chk("rst_in_rdy", 32'(a.in_rdy), 32'd1);

    // Single word, wrap and saturate corners
    single_a("t1", 8'h05, MODE_WRAP, 8'h07, 1'b0);
    single_a("t2_wrap", 8'hFF, MODE_WRAP, 8'h01, 1'b1);
    single_a("t2_sat", 8'hFE, MODE_SAT, 8'hFF, 1'b1);
    single_a("t2_sat_edge", 8'hFD, MODE_SAT, 8'hFF, 1'b0);

    // Back-pressure then release
    outq_a.delete();
    n = 0; nxt = 8'h10;
    for (int i = 0; i < 5; i++) begin
      step_a(1'b1, nxt, MODE_WRAP, 1'b0, acc);
      if (acc) begin nxt++; n++; end
    end
    chk("t3_accepted", 32'(n), 32'd2);
    chk("t3_in_rdy", 32'(a.in_rdy), 32'd0);
    chk("t3_occ", 32'(a.occupancy), 32'd2);
    chk("t3_out_val", 32'(a.out_val), 32'd1);
    chk("t3_hold_msg", 32'(a.out_msg), 32'h12);
    chk("t3_none_out", 32'(outq_a.size()), 32'd0);
    for (int i = 0; i < 30 && outq_a.size() < 6; i++) begin
      step_a(nxt <= 8'h15, nxt, MODE_WRAP, 1'b1, acc);
      if (acc) nxt++;
    end
    chk("t3_count", 32'(outq_a.size()), 32'd6);
    for (int i = 0; i < outq_a.size(); i++)
      chk($sformatf("t3_out%0d", i), 32'(outq_a[i]), 32'h12 + 32'(i));

    // Full throughput
    step_a(1'b0, 8'h00, MODE_WRAP, 1'b1, acc);
    outq_a.delete(); outcyc_a.delete();
    cyc = 0; n = 0; nxt = 8'h30;
    for (int i = 0; i < 40 && outq_a.size() < 20; i++) begin
      step_a(n < 20, nxt, MODE_WRAP, 1'b1, acc);
      if (acc) begin n++; nxt++; end
    end
    chk("t4_accepted", 32'(n), 32'd20);
    chk("t4_count", 32'(outq_a.size()), 32'd20);
    if (outq_a.size() == 20) begin
      chk("t4_first_cycle", 32'(outcyc_a[0]), 32'd2);
      chk("t4_span", 32'(outcyc_a[19] - outcyc_a[0]), 32'd19);
      for (int i = 0; i < 20; i++)
        chk($sformatf("t4_out%0d", i), 32'(outq_a[i]), 32'h32 + 32'(i));
    end
    step_a(1'b0, 8'h00, MODE_WRAP, 1'b1, acc);

    // Reset mid-stream
    step_a(1'b1, 8'h50, MODE_WRAP, 1'b0, acc);
    step_a(1'b1, 8'h51, MODE_WRAP, 1'b0, acc);
    step_a(1'b0, 8'h00, MODE_WRAP, 1'b0, acc);
    chk("t5_occ_full", 32'(a.occupancy), 32'd2);
    #2 reset = 1'b0;
    #1;
    chk("t5_async_val", 32'(a.out_val), 32'd0);
    chk("t5_async_occ", 32'(a.occupancy), 32'd0);
    chk("t5_async_msg", 32'(a.out_msg), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    single_a("t5_after", 8'h20, MODE_WRAP, 8'h22, 1'b0);

    // Four-stage, STEP=0x40 instance
    single_b("t6_wrap", 8'h00, MODE_WRAP, 8'h00, 1'b1);
    single_b("t6_sat", 8'h00, MODE_SAT, 8'hFF, 1'b1);

    got = 0; sent = 0; prev_stall = 1'b0; prev_out = '0;
    for (int c = 0; c < 20000 && got < 1000; c++) begin
      @(negedge clk);
      b.in_val  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      b.in_msg  = 8'($urandom);
      b.in_sat  = 1'($urandom);
      b.out_rdy = ($urandom_range(0, 2) != 0);
      #1;
      if (prev_stall) chk("t6_hold", 32'({b.out_ovf, b.out_msg}), 32'(prev_out));
      chk("t6_occ", 32'(b.occupancy), 32'(exp_q.size()));
      chk("t6_in_rdy", 32'(b.in_rdy), 32'((exp_q.size() < 4) || b.out_rdy));
      if (b.out_val && b.out_rdy) begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("t6_word", 32'({b.out_ovf, b.out_msg}), 32'(e));
        end else begin
          chk("t6_spurious", 32'(exp_q.size()), 32'd1);
        end
        got++;
      end
      if (b.in_val && b.in_rdy) begin
        exp_q.push_back(model_b(b.in_msg, b.in_sat));
        sent++;
      end
      prev_stall = b.out_val && !b.out_rdy;
      prev_out   = {b.out_ovf, b.out_msg};
    end
    chk("t6_words", 32'(got), 32'd1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
